// File: rtl/data_mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
// - state_t: arbiter FSM states (IDLE / ISSUE / RESP)
// - MASK_*: size field encodings of the 4-bit sign/size mask ([3] = sign-extend)
// - PORT_*: requester ids (C = CPU load/store path, D = debug/DMA master)
// - access_illegal(): size/alignment legality check of one command
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [2:0] MASK_BYTE = 3'b001;
  localparam logic [2:0] MASK_HALF = 3'b011;
  localparam logic [2:0] MASK_WORD = 3'b111;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Returns 1 when the access must not reach memory: unknown size code,
  // odd halfword, or unaligned word. The LED register address is passed
  // through untouched, so it is never alignment-checked.
  function automatic logic access_illegal(input logic [31:0] addr,
                                          input logic [2:0]  size,
                                          input logic        led_exempt);
    logic bad;
    bad = 1'b0;
    case (size)
      MASK_BYTE: bad = 1'b0;
      MASK_HALF: bad = addr[0] & ~led_exempt;
      MASK_WORD: bad = (addr[1:0] != 2'b00) & ~led_exempt;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way arbiter pick with its last-grant history register.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   c_req, d_req      requests from port C and port D
//   accept            1 = the current pick is taken; record it as last grant
//   winner            selected port id (PORT_C / PORT_D), combinational
//   any_req           at least one request is present
// PRIO_MODE 0 alternates on ties; PRIO_MODE 1 always favours port C.
module rr_arb2
  import data_mem_arb_pkg::*;
#(
  parameter int PRIO_MODE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic c_req,
  input  logic d_req,
  input  logic accept,
  output logic winner,
  output logic any_req
);

  logic last_gnt_q;
  logic last_gnt_d;

  always_comb begin
    any_req = c_req | d_req;
    winner  = PORT_C;
    if (c_req && d_req) begin
      // On a tie the port that did not win last time goes next.
      winner = (PRIO_MODE == 1) ? PORT_C : ~last_gnt_q;
    end else if (d_req) begin
      winner = PORT_D;
    end
    last_gnt_d = accept ? winner : last_gnt_q;
  end

  // Starting with D as last grant lets C win the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= PORT_D;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single data-memory port between the CPU load/store path (C)
// and a debug/DMA master (D). The winning command is registered, checked
// for legality and driven to memory for one cycle; load data returned one
// cycle later is handed back to the winner.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   {c,d}_req/_we/_addr/_wdata/_sign_mask   requester command inputs
//   {c,d}_gnt                      one-cycle pulse: command accepted and issued
//   {c,d}_err                      with gnt: access rejected, memory untouched
//   {c,d}_rvalid / _rdata          load-result pulse / held load result
//   mem_addr, mem_write_data, mem_sign_mask   registered command to memory
//   mem_memread, mem_memwrite      strobes, high only in ISSUE
//   mem_read_data                  memory read data, valid the cycle after memread
//   busy                           arbiter is not idle
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int          PRIO_MODE = 0,
  parameter logic [31:0] LED_ADDR  = 32'h2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [3:0]  c_sign_mask,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sign_mask,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_err,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_sign_mask,
  output logic        mem_memread,
  output logic        mem_memwrite,
  input  logic [31:0] mem_read_data,
  output logic        busy
);

  state_t      state_q, state_d;
  logic        port_q, port_d;
  logic        c_gnt_q, c_gnt_d;
  logic        d_gnt_q, d_gnt_d;
  logic        c_err_q, c_err_d;
  logic        d_err_q, d_err_d;
  logic        c_rvalid_q, c_rvalid_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] c_rdata_q, c_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic [3:0]  mem_sign_mask_q, mem_sign_mask_d;
  logic        mem_memread_q, mem_memread_d;
  logic        mem_memwrite_q, mem_memwrite_d;

  logic        winner;
  logic        any_req;
  logic        accept;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_mask;
  logic        sel_illegal;

  // Requests are only looked at while idle.
  assign accept = (state_q == ST_IDLE) && any_req;

  rr_arb2 #(
    .PRIO_MODE(PRIO_MODE)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .c_req  (c_req),
    .d_req  (d_req),
    .accept (accept),
    .winner (winner),
    .any_req(any_req)
  );

  always_comb begin
    sel_we      = (winner == PORT_D) ? d_we        : c_we;
    sel_addr    = (winner == PORT_D) ? d_addr      : c_addr;
    sel_wdata   = (winner == PORT_D) ? d_wdata     : c_wdata;
    sel_mask    = (winner == PORT_D) ? d_sign_mask : c_sign_mask;
    sel_illegal = access_illegal(sel_addr, sel_mask[2:0], sel_addr == LED_ADDR);
  end

  always_comb begin
    state_d          = state_q;
    port_d           = port_q;
    c_gnt_d          = 1'b0;
    d_gnt_d          = 1'b0;
    c_err_d          = 1'b0;
    d_err_d          = 1'b0;
    c_rvalid_d       = 1'b0;
    d_rvalid_d       = 1'b0;
    c_rdata_d        = c_rdata_q;
    d_rdata_d        = d_rdata_q;
    mem_addr_d       = mem_addr_q;
    mem_write_data_d = mem_write_data_q;
    mem_sign_mask_d  = mem_sign_mask_q;
    mem_memread_d    = 1'b0;
    mem_memwrite_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Everything visible in ISSUE is computed here so that gnt, err
          // and the strobes come straight out of flops.
          port_d           = winner;
          mem_addr_d       = sel_addr;
          mem_write_data_d = sel_wdata;
          mem_sign_mask_d  = sel_mask;
          mem_memread_d    = ~sel_illegal & ~sel_we;
          mem_memwrite_d   = ~sel_illegal & sel_we;
          c_gnt_d          = (winner == PORT_C);
          d_gnt_d          = (winner == PORT_D);
          c_err_d          = (winner == PORT_C) & sel_illegal;
          d_err_d          = (winner == PORT_D) & sel_illegal;
          state_d          = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Only a legal load needs the response cycle.
        state_d = mem_memread_q ? ST_RESP : ST_IDLE;
      end
      ST_RESP: begin
        if (port_q == PORT_D) begin
          d_rdata_d  = mem_read_data;
          d_rvalid_d = 1'b1;
        end else begin
          c_rdata_d  = mem_read_data;
          c_rvalid_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      port_q           <= PORT_C;
      c_gnt_q          <= 1'b0;
      d_gnt_q          <= 1'b0;
      c_err_q          <= 1'b0;
      d_err_q          <= 1'b0;
      c_rvalid_q       <= 1'b0;
      d_rvalid_q       <= 1'b0;
      c_rdata_q        <= 32'h0;
      d_rdata_q        <= 32'h0;
      mem_addr_q       <= 32'h0;
      mem_write_data_q <= 32'h0;
      mem_sign_mask_q  <= 4'h0;
      mem_memread_q    <= 1'b0;
      mem_memwrite_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      port_q           <= port_d;
      c_gnt_q          <= c_gnt_d;
      d_gnt_q          <= d_gnt_d;
      c_err_q          <= c_err_d;
      d_err_q          <= d_err_d;
      c_rvalid_q       <= c_rvalid_d;
      d_rvalid_q       <= d_rvalid_d;
      c_rdata_q        <= c_rdata_d;
      d_rdata_q        <= d_rdata_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_data_q <= mem_write_data_d;
      mem_sign_mask_q  <= mem_sign_mask_d;
      mem_memread_q    <= mem_memread_d;
      mem_memwrite_q   <= mem_memwrite_d;
    end
  end

  assign c_gnt          = c_gnt_q;
  assign d_gnt          = d_gnt_q;
  assign c_err          = c_err_q;
  assign d_err          = d_err_q;
  assign c_rvalid       = c_rvalid_q;
  assign d_rvalid       = d_rvalid_q;
  assign c_rdata        = c_rdata_q;
  assign d_rdata        = d_rdata_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_sign_mask  = mem_sign_mask_q;
  assign mem_memread    = mem_memread_q;
  assign mem_memwrite   = mem_memwrite_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: stimulus pushes expected grant and
// read-response records; a negedge monitor pops and compares them whenever
// the DUT shows gnt or rvalid. A second instance in fixed-priority mode is
// checked directly for d starvation.
module tb_data_mem_arbiter;

  typedef struct packed {
    logic        port;
    logic        err;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] cyc;
  } exp_t;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [3:0]  c_sign_mask, d_sign_mask;
  logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_memread, mem_memwrite, busy;

  logic        fp_c_gnt, fp_c_rvalid, fp_c_err, fp_d_gnt, fp_d_rvalid, fp_d_err;
  logic [31:0] fp_c_rdata, fp_d_rdata, fp_mem_addr, fp_mem_write_data;
  logic [3:0]  fp_mem_sign_mask;
  logic        fp_mem_memread, fp_mem_memwrite, fp_busy;

  int   tests;
  int   fails;
  int   cyc;
  exp_t gnt_sb[$];
  exp_t rv_sb[$];
  vec_t vecs[10];

  data_mem_arbiter #(.PRIO_MODE(0), .LED_ADDR(32'h2000)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_sign_mask(c_sign_mask),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sign_mask(d_sign_mask),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_sign_mask(mem_sign_mask),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  data_mem_arbiter #(.PRIO_MODE(1), .LED_ADDR(32'h2000)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_sign_mask(c_sign_mask),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sign_mask(d_sign_mask),
    .c_gnt(fp_c_gnt), .c_rvalid(fp_c_rvalid), .c_rdata(fp_c_rdata), .c_err(fp_c_err),
    .d_gnt(fp_d_gnt), .d_rvalid(fp_d_rvalid), .d_rdata(fp_d_rdata), .d_err(fp_d_err),
    .mem_addr(fp_mem_addr), .mem_write_data(fp_mem_write_data), .mem_sign_mask(fp_mem_sign_mask),
    .mem_memread(fp_mem_memread), .mem_memwrite(fp_mem_memwrite),
    .mem_read_data(mem_read_data), .busy(fp_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory read model: data appears only in the cycle after mem_memread.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h1004) return 32'hDEADBEEF;
    return a ^ 32'h5A5A0000;
  endfunction

  initial begin
    logic        pend;
    logic [31:0] paddr;
    mem_read_data = 32'h0;
    forever begin
      @(negedge clk);
      pend  = mem_memread;
      paddr = mem_addr;
      @(posedge clk);
      #1;
      mem_read_data = pend ? mem_model(paddr) : 32'hBAD0BAD0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every presented gnt / rvalid against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (gnt_sb.size() > 0 && int'(gnt_sb[0].cyc) < cyc) begin
          e = gnt_sb.pop_front();
          chk("gnt_missing_cyc", cyc, e.cyc);
        end
        if (rv_sb.size() > 0 && int'(rv_sb[0].cyc) < cyc) begin
          e = rv_sb.pop_front();
          chk("rvalid_missing_cyc", cyc, e.cyc);
        end
        chk("err_without_gnt", 32'({c_err & ~c_gnt, d_err & ~d_gnt}), 32'h0);
        chk("strobe_without_gnt", 32'((mem_memread | mem_memwrite) & ~(c_gnt | d_gnt)), 32'h0);
        if (c_gnt || d_gnt) begin
          $display("[TB] cyc %0d gnt c=%0d d=%0d err=%0d rd=%0d wr=%0d addr=%h wdata=%h",
                   cyc, c_gnt, d_gnt, c_err | d_err, mem_memread, mem_memwrite, mem_addr, mem_write_data);
          chk("dual_gnt", 32'(c_gnt & d_gnt), 32'h0);
          if (gnt_sb.size() == 0) begin
            chk("unexpected_gnt", 32'({c_gnt, d_gnt}), 32'h0);
          end else begin
            e = gnt_sb.pop_front();
            chk("gnt_cyc", cyc, e.cyc);
            chk("gnt_port", 32'(d_gnt), 32'(e.port));
            chk("gnt_err", 32'(d_gnt ? d_err : c_err), 32'(e.err));
            chk("mem_memread", 32'(mem_memread), 32'(e.rd));
            chk("mem_memwrite", 32'(mem_memwrite), 32'(e.wr));
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_write_data", mem_write_data, e.data);
            chk("mem_sign_mask", 32'(mem_sign_mask), 32'(e.mask));
          end
        end
        if (c_rvalid || d_rvalid) begin
          $display("[TB] cyc %0d rvalid c=%0d d=%0d c_rdata=%h d_rdata=%h",
                   cyc, c_rvalid, d_rvalid, c_rdata, d_rdata);
          if (rv_sb.size() == 0) begin
            chk("unexpected_rvalid", 32'({c_rvalid, d_rvalid}), 32'h0);
          end else begin
            e = rv_sb.pop_front();
            chk("rvalid_cyc", cyc, e.cyc);
            chk("rvalid_port", 32'({c_rvalid, d_rvalid}), e.port ? 32'h1 : 32'h2);
            chk("rdata", d_rvalid ? d_rdata : c_rdata, e.data);
          end
        end
      end
    end
  end

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask);
    if (port) begin
      d_req = req; d_we = we; d_addr = addr; d_wdata = wdata; d_sign_mask = mask;
    end else begin
      c_req = req; c_we = we; c_addr = addr; c_wdata = wdata; c_sign_mask = mask;
    end
  endtask

  task automatic push_gnt(input logic port, input logic err, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, input int at);
    exp_t e;
    e.port = port; e.err = err; e.rd = rd; e.wr = wr;
    e.addr = addr; e.data = data; e.mask = mask; e.cyc = 32'(at);
    gnt_sb.push_back(e);
  endtask

  task automatic push_rv(input logic port, input logic [31:0] data, input int at);
    exp_t e;
    e = '0;
    e.port = port; e.data = data; e.cyc = 32'(at);
    rv_sb.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, 32'({c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err,
                             mem_memread, mem_memwrite, busy}), 32'h0);
    chk({tag, "_c_rdata"}, c_rdata, 32'h0);
    chk({tag, "_d_rdata"}, d_rdata, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_write_data, 32'h0);
    chk({tag, "_mem_mask"}, 32'(mem_sign_mask), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One isolated request; expected gnt at T+1 and, for legal loads, rvalid at T+3.
  task automatic run_vec(input vec_t v);
    int   n;
    logic rd, wr;
    n  = cyc;
    rd = ~v.err & ~v.we;
    wr = ~v.err & v.we;
    $display("[TB] cyc %0d issue port=%0d we=%0d addr=%h wdata=%h mask=%b", n, v.port, v.we, v.addr, v.wdata, v.mask);
    drive(v.port, 1'b1, v.we, v.addr, v.wdata, v.mask);
    push_gnt(v.port, v.err, rd, wr, v.addr, v.wdata, v.mask, n + 1);
    if (rd) push_rv(v.port, v.rdata, n + 3);
    @(negedge clk);
    chk("busy_in_issue", 32'(busy), 32'h1);
    drive(v.port, 1'b0, v.we, v.addr, v.wdata, v.mask);
    @(negedge clk);
    chk("busy_after_issue", 32'(busy), 32'(rd));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    tests = 0;
    fails = 0;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    //            port  we    addr          wdata         mask     err   rdata
    vecs[0] = '{1'b0, 1'b0, 32'h00001004, 32'h00000000, 4'b0111, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h00001003, 32'h00000033, 4'b0011, 1'b1, 32'h00000000};
    vecs[2] = '{1'b0, 1'b1, 32'h00002000, 32'h0000005A, 4'b0111, 1'b0, 32'h00000000};
    vecs[3] = '{1'b0, 1'b1, 32'h00001002, 32'h00000044, 4'b0111, 1'b1, 32'h00000000};
    vecs[4] = '{1'b0, 1'b0, 32'h00001000, 32'h00000000, 4'b0101, 1'b1, 32'h00000000};
    vecs[5] = '{1'b1, 1'b0, 32'h00001001, 32'h00000000, 4'b1001, 1'b0, 32'h5A5A1001};
    vecs[6] = '{1'b0, 1'b0, 32'h00001002, 32'h00000000, 4'b0011, 1'b0, 32'h5A5A1002};
    vecs[7] = '{1'b1, 1'b1, 32'h00001003, 32'h00000077, 4'b0001, 1'b0, 32'h00000000};
    vecs[8] = '{1'b1, 1'b0, 32'h00001000, 32'h00000000, 4'b0000, 1'b1, 32'h00000000};
    vecs[9] = '{1'b1, 1'b0, 32'h00001004, 32'h00000000, 4'b1111, 1'b0, 32'hDEADBEEF};

    do_reset();

    // c-only word load; d side must stay quiet.
    run_vec(vecs[0]);
    chk("d_rdata_untouched", d_rdata, 32'h0);
    chk("c_rdata_held", c_rdata, 32'hDEADBEEF);

    // Simultaneous stores after reset: c first, d two cycles later.
    do_reset();
    n = cyc;
    drive(1'b0, 1'b1, 1'b1, 32'h00000100, 32'h11111111, 4'b0111);
    drive(1'b1, 1'b1, 1'b1, 32'h00000200, 32'h22222222, 4'b0111);
    push_gnt(1'b0, 1'b0, 1'b0, 1'b1, 32'h00000100, 32'h11111111, 4'b0111, n + 1);
    push_gnt(1'b1, 1'b0, 1'b0, 1'b1, 32'h00000200, 32'h22222222, 4'b0111, n + 3);
    @(negedge clk);
    c_req = 1'b0;
    repeat (2) @(negedge clk);
    d_req = 1'b0;
    repeat (2) @(negedge clk);

    // Both held: grants alternate c, d, c, d.
    n = cyc;
    c_req = 1'b1;
    d_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        push_gnt(1'b0, 1'b0, 1'b0, 1'b1, 32'h00000100, 32'h11111111, 4'b0111, n + 1 + 2 * i);
      else
        push_gnt(1'b1, 1'b0, 1'b0, 1'b1, 32'h00000200, 32'h22222222, 4'b0111, n + 1 + 2 * i);
    end
    repeat (7) @(negedge clk);
    c_req = 1'b0;
    d_req = 1'b0;
    repeat (3) @(negedge clk);

    // Directed table: illegal sizes/alignment, LED store, loads of each size.
    for (int i = 1; i < 10; i++) run_vec(vecs[i]);

    // Reset during RESP of a c load: no rvalid may follow.
    n = cyc;
    drive(1'b0, 1'b1, 1'b0, 32'h00001004, 32'h0, 4'b0111);
    push_gnt(1'b0, 1'b0, 1'b1, 1'b0, 32'h00001004, 32'h0, 4'b0111, n + 1);
    @(negedge clk);
    c_req = 1'b0;
    @(negedge clk);
    chk("busy_in_resp", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_resp_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_vec(vecs[0]);

    // Continuous store requests: round-robin alternates, fixed priority starves d.
    do_reset();
    n = cyc;
    drive(1'b0, 1'b1, 1'b1, 32'h00000300, 32'h0000C0C0, 4'b0111);
    drive(1'b1, 1'b1, 1'b1, 32'h00000400, 32'h0000D0D0, 4'b0111);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0)
        push_gnt(1'b0, 1'b0, 1'b0, 1'b1, 32'h00000300, 32'h0000C0C0, 4'b0111, n + 1 + 2 * i);
      else
        push_gnt(1'b1, 1'b0, 1'b0, 1'b1, 32'h00000400, 32'h0000D0D0, 4'b0111, n + 1 + 2 * i);
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("fp_c_gnt", 32'(fp_c_gnt), 32'(k % 2));
      chk("fp_d_gnt", 32'(fp_d_gnt), 32'h0);
      if (k == 19) begin
        c_req = 1'b0;
        d_req = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    chk("gnt_scoreboard_left", 32'(gnt_sb.size()), 32'h0);
    chk("rvalid_scoreboard_left", 32'(rv_sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
